// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM types, constants and rate helper
// Shared with the PDM deserializer so both ends agree on framing and rate.
package pdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pdm_state_t;

    // 50 % ones density: the amplifier hears this as silence.
    localparam logic [15:0] PDM_IDLE_WORD = 16'hAAAA;

    // System clocks per PDM bit.
    function automatic int pdm_period(input int system_frequency, input int sampling_frequency);
        return system_frequency / sampling_frequency;
    endfunction

endpackage

// File: rtl/pdm_clock_divider.sv
// rtl/pdm_clock_divider.sv - PDM bit clock divider with bit-step strobe
// Ports:
//   clk, resetn : system clock, synchronous active-low reset
//   run         : divider output enable (clock and strobe gated low otherwise)
//   load        : force div to H next cycle (start of a bit window)
//   clear       : force div to 0 next cycle (lower priority than load)
//   pdm_clk     : high while div < H
//   bit_step    : one-cycle strobe at div == H-1, just before the falling edge
module pdm_clock_divider #(
    parameter int P = 100
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic load,
    input  logic clear,
    output logic pdm_clk,
    output logic bit_step
);

    localparam int H  = P / 2;
    localparam int DW = $clog2(P);

    localparam logic [DW-1:0] H_V  = DW'(H);
    localparam logic [DW-1:0] H_M1 = DW'(H - 1);
    localparam logic [DW-1:0] P_M1 = DW'(P - 1);

    if (((P % 2) != 0) || (P < 4)) begin : g_bad_period
        $error("pdm_clock_divider: period must be even and at least 4");
    end

    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div <= '0;
        end else if (load) begin
            div <= H_V;
        end else if (clear) begin
            div <= '0;
        end else if (div == P_M1) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // The falling edge (div wrapping into H) is where a new bit is presented,
    // so the receiver's rising edge lands mid-bit.
    assign pdm_clk  = run && (div < H_V);
    assign bit_step = run && (div == H_M1);

endmodule

// File: rtl/pdm_serializer.sv
// rtl/pdm_serializer.sv - word-to-PDM serializer with one-word holding register
// Ports:
//   clock_i, reset_n_i : system clock, synchronous active-low reset
//   enable_i           : run enable
//   data_i, valid_i    : word in; accepted when valid_i && ready_o
//   ready_o            : holding register empty
//   done_o             : pulse when a word is loaded into the shifter
//   underrun_o         : pulse when IDLE_WORD is loaded for lack of a word
//   pdm_clk_o          : PDM bit clock
//   pdm_data_o         : PDM bit stream, MSB first
//   audio_sd_o         : amplifier enable, high in RUN
module pdm_serializer
    import pdm_pkg::*;
#(
    parameter int                     WORD_LENGTH        = 16,
    parameter int                     SYSTEM_FREQUENCY   = 100000000,
    parameter int                     SAMPLING_FREQUENCY = 1000000,
    parameter logic [WORD_LENGTH-1:0] IDLE_WORD          = WORD_LENGTH'(PDM_IDLE_WORD)
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic [WORD_LENGTH-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   done_o,
    output logic                   underrun_o,
    output logic                   pdm_clk_o,
    output logic                   pdm_data_o,
    output logic                   audio_sd_o
);

    localparam int P  = pdm_period(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
    localparam int BW = $clog2(WORD_LENGTH);

    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LENGTH - 1);

    pdm_state_t             state;
    pdm_state_t             state_next;
    logic [WORD_LENGTH-1:0] hold;
    logic                   hold_valid;
    logic [WORD_LENGTH-1:0] sh;
    logic [BW-1:0]          bi;

    logic bit_step;
    logic accept;
    logic start;
    logic shift;
    logic word_end;
    logic consume;
    logic div_load;
    logic div_clear;

    assign accept = valid_i && !hold_valid;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift      = 1'b0;
        word_end   = 1'b0;
        div_load   = 1'b0;
        div_clear  = 1'b0;
        case (state)
            IDLE: begin
                div_clear = 1'b1;
                if (enable_i && hold_valid) begin
                    state_next = RUN;
                    start      = 1'b1;
                    div_load   = 1'b1;
                end
            end
            RUN: begin
                // Disable wins over a coincident bit step: the partial word is dropped.
                if (!enable_i) begin
                    state_next = IDLE;
                    div_clear  = 1'b1;
                end else if (bit_step) begin
                    div_load = 1'b1;
                    if (bi == LAST_BIT) begin
                        word_end = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // consume needs hold_valid and accept needs !hold_valid, so they never coincide.
    assign consume = start || (word_end && hold_valid);

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            sh         <= '0;
            bi         <= '0;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            done_o     <= consume;
            underrun_o <= word_end && !hold_valid;

            if (consume) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold       <= data_i;
                hold_valid <= 1'b1;
            end

            if (consume) begin
                sh <= hold;
            end else if (word_end) begin
                sh <= IDLE_WORD;
            end else if (shift) begin
                sh <= sh << 1;
            end

            if (shift) begin
                bi <= bi + 1'b1;
            end else if (start || word_end || (state_next == IDLE)) begin
                bi <= '0;
            end
        end
    end

    pdm_clock_divider #(
        .P(P)
    ) u_div (
        .clk     (clock_i),
        .resetn  (reset_n_i),
        .run     (state == RUN),
        .load    (div_load),
        .clear   (div_clear),
        .pdm_clk (pdm_clk_o),
        .bit_step(bit_step)
    );

    assign ready_o    = !hold_valid;
    assign audio_sd_o = (state == RUN);
    assign pdm_data_o = (state == RUN) && sh[WORD_LENGTH-1];

endmodule
